// File: rtl/pp_pipeline_accel_df_pkg.sv
// Shared constants and in-flight counter helper for the pp_pipeline_accel dataflow start controller.
package pp_pipeline_accel_df_pkg;
  localparam int MAX_INFLIGHT_DEF = 3;
  localparam int CNT_W_DEF        = 2;
  localparam int FRAME_CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    CNT_HOLD  = 2'd0,
    CNT_INC   = 2'd1,
    CNT_DEC   = 2'd2,
    CNT_UFLOW = 2'd3
  } cnt_op_e;

  // A simultaneous accept and done capture cancel out; a lone capture on an
  // empty pipeline is an underflow and leaves the count at zero.
  function automatic cnt_op_e cnt_op(input logic acc, input logic cap, input logic empty);
    cnt_op_e op;
    op = CNT_HOLD;
    if (acc && !cap)                op = CNT_INC;
    else if (cap && !acc && !empty) op = CNT_DEC;
    else if (cap && !acc && empty)  op = CNT_UFLOW;
    return op;
  endfunction
endpackage

// File: rtl/pp_pipeline_accel_df_done_hold.sv
// Captures a sink stage's done into a held flag until the consumer acknowledges it.
module pp_pipeline_accel_df_done_hold (
  input  logic clk,
  input  logic rst_n,
  input  logic done_i,
  input  logic continue_i,
  output logic hold_o,
  output logic capture_o,
  output logic ready_o
);
  logic hold_q, hold_d;

  // Ready is low while holding, so a done arriving in the clear cycle waits one cycle.
  assign ready_o   = ~hold_q;
  assign capture_o = done_i & ~hold_q;
  assign hold_o    = hold_q;

  always_comb begin
    hold_d = hold_q;
    if (capture_o)                hold_d = 1'b1;
    else if (continue_i && hold_q) hold_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= 1'b0;
    else        hold_q <= hold_d;
  end
endmodule

// File: rtl/pp_pipeline_accel_df_start_ctrl.sv
// Dataflow start/done sequencer: gates starts by in-flight depth, pushes start tokens, holds ap_done.
module pp_pipeline_accel_df_start_ctrl
  import pp_pipeline_accel_df_pkg::*;
#(
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int FRAME_CNT_W  = FRAME_CNT_W_DEF
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   ap_start,
  output logic                   ap_ready,
  output logic                   ap_done,
  input  logic                   ap_continue,
  output logic                   ap_idle,
  output logic                   s0_ap_start,
  input  logic                   s0_ap_ready,
  output logic                   sf_write,
  input  logic                   sf_full_n,
  input  logic                   last_ap_done,
  output logic                   last_ap_continue,
  output logic [CNT_W-1:0]       inflight,
  output logic [FRAME_CNT_W-1:0] frames_started,
  output logic [FRAME_CNT_W-1:0] frames_done,
  output logic                   err_underflow
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0]       inflight_q, inflight_d;
  logic                   token_pending_q, token_pending_d;
  logic [FRAME_CNT_W-1:0] started_q, started_d;
  logic [FRAME_CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic                   err_q, err_d;
  logic                   acc, cap, hold;
  cnt_op_e                op;

  pp_pipeline_accel_df_done_hold u_done_hold (
    .clk        (ap_clk),
    .rst_n      (ap_rst_n),
    .done_i     (last_ap_done),
    .continue_i (ap_continue),
    .hold_o     (hold),
    .capture_o  (cap),
    .ready_o    (last_ap_continue)
  );

  // A pending token blocks new starts so at most one token is ever outstanding.
  assign s0_ap_start = ap_start & ~token_pending_q & (inflight_q < MAX_C);
  assign acc         = s0_ap_start & s0_ap_ready;
  assign ap_ready    = acc;
  assign sf_write    = acc | token_pending_q;
  assign ap_done     = hold;
  assign ap_idle     = (inflight_q == '0) & ~hold & ~token_pending_q;

  assign inflight       = inflight_q;
  assign frames_started = started_q;
  assign frames_done    = done_cnt_q;
  assign err_underflow  = err_q;

  assign op = cnt_op(acc, cap, inflight_q == '0);

  always_comb begin
    inflight_d      = inflight_q;
    err_d           = err_q | (cap & (inflight_q == '0));
    token_pending_d = sf_write & ~sf_full_n;
    started_d       = started_q + FRAME_CNT_W'(acc);
    done_cnt_d      = done_cnt_q + FRAME_CNT_W'(cap);
    case (op)
      CNT_INC:  inflight_d = inflight_q + CNT_W'(1);
      CNT_DEC:  inflight_d = inflight_q - CNT_W'(1);
      default:  inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      inflight_q      <= '0;
      token_pending_q <= 1'b0;
      started_q       <= '0;
      done_cnt_q      <= '0;
      err_q           <= 1'b0;
    end else begin
      inflight_q      <= inflight_d;
      token_pending_q <= token_pending_d;
      started_q       <= started_d;
      done_cnt_q      <= done_cnt_d;
      err_q           <= err_d;
    end
  end
endmodule

// File: tb/tb_pp_pipeline_accel_df_start_ctrl.sv
// Directed scenarios plus randomized traffic against a frame-level reference model.
module tb_pp_pipeline_accel_df_start_ctrl;
  logic        ap_clk = 1'b0;
  logic        ap_rst_n, ap_start, ap_continue, s0_ap_ready, sf_full_n, last_ap_done;
  logic        ap_ready, ap_done, ap_idle, s0_ap_start, sf_write, last_ap_continue, err_underflow;
  logic [1:0]  inflight;
  logic [15:0] frames_started, frames_done;

  int checks = 0;
  int errors = 0;

  // reference model: frames in flight as an integer, flags as bits
  int m_inflight, m_started, m_done;
  bit m_pending, m_hold, m_err;

  always #5 ap_clk = ~ap_clk;

  pp_pipeline_accel_df_start_ctrl dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .ap_idle(ap_idle),
    .s0_ap_start(s0_ap_start), .s0_ap_ready(s0_ap_ready), .sf_write(sf_write),
    .sf_full_n(sf_full_n), .last_ap_done(last_ap_done), .last_ap_continue(last_ap_continue),
    .inflight(inflight), .frames_started(frames_started), .frames_done(frames_done),
    .err_underflow(err_underflow)
  );

  function automatic bit m_gate();
    return ap_start && !m_pending && (m_inflight < 3);
  endfunction

  function automatic bit m_acc();
    return m_gate() && s0_ap_ready;
  endfunction

  // Advance one clock; the model consumes the inputs that were stable before the edge.
  task automatic tick();
    bit acc, wr, cap, cont, full_n;
    acc = m_acc(); wr = acc || m_pending; cap = last_ap_done && !m_hold;
    cont = ap_continue; full_n = sf_full_n;
    @(posedge ap_clk); #1;
    if (cap && m_inflight == 0) m_err = 1;
    if (acc && !cap) m_inflight++;
    else if (cap && !acc && m_inflight > 0) m_inflight--;
    m_pending = wr && !full_n;
    if (cap) m_hold = 1; else if (cont && m_hold) m_hold = 0;
    if (acc) m_started = (m_started + 1) % 65536;
    if (cap) m_done = (m_done + 1) % 65536;
  endtask

  task automatic clear_inputs();
    ap_start = 0; ap_continue = 0; s0_ap_ready = 0; sf_full_n = 1; last_ap_done = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    ap_rst_n = 0;
    repeat (5) @(posedge ap_clk);
    #1 ap_rst_n = 1;
    m_inflight = 0; m_started = 0; m_done = 0; m_pending = 0; m_hold = 0; m_err = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ap_idle, last_ap_continue, ap_ready, ap_done, s0_ap_start, sf_write, err_underflow} !== 7'b1100000) begin
      errors++; $display("FAIL reset_flags got=%b want=1100000",
        {ap_idle, last_ap_continue, ap_ready, ap_done, s0_ap_start, sf_write, err_underflow});
    end
    checks++;
    if (inflight !== 2'd0 || frames_started !== 16'd0 || frames_done !== 16'd0) begin
      errors++; $display("FAIL reset_counters got=%0d/%0d/%0d want=0/0/0", inflight, frames_started, frames_done);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    ap_start = 1; s0_ap_ready = 1; #1;
    checks++;
    if (ap_ready !== 1'b1 || sf_write !== 1'b1) begin
      errors++; $display("FAIL single_accept ready=%b write=%b want=1/1", ap_ready, sf_write);
    end
    tick(); ap_start = 0; s0_ap_ready = 0;
    checks++;
    if (inflight !== 2'd1) begin errors++; $display("FAIL single_inflight got=%0d want=1", inflight); end
    last_ap_done = 1; tick(); last_ap_done = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ap_done !== 1'b1) begin errors++; $display("FAIL single_done_held cyc=%0d got=%b want=1", i, ap_done); end
      tick();
    end
    ap_continue = 1; tick(); ap_continue = 0;
    checks++;
    if (ap_done !== 1'b0 || inflight !== 2'd0 || frames_done !== 16'd1 || ap_idle !== 1'b1) begin
      errors++; $display("FAIL single_complete done=%b infl=%0d fdone=%0d idle=%b want=0/0/1/1",
        ap_done, inflight, frames_done, ap_idle);
    end
  endtask

  task automatic test_back_pressure();
    int accepts = 0;
    do_reset();
    ap_start = 1; s0_ap_ready = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (ap_ready === 1'b1) accepts++;
      checks++;
      if (ap_ready !== (i < 3)) begin errors++; $display("FAIL bp_accept_seq cyc=%0d got=%b want=%b", i, ap_ready, i < 3); end
      tick();
    end
    checks++;
    if (accepts != 3 || s0_ap_start !== 1'b0 || inflight !== 2'd3) begin
      errors++; $display("FAIL bp_full accepts=%0d s0=%b infl=%0d want=3/0/3", accepts, s0_ap_start, inflight);
    end
    last_ap_done = 1; tick(); last_ap_done = 0;
    checks++;
    if (inflight !== 2'd2 || s0_ap_start !== 1'b1 || ap_ready !== 1'b1) begin
      errors++; $display("FAIL bp_reopen infl=%0d s0=%b rdy=%b want=2/1/1", inflight, s0_ap_start, ap_ready);
    end
    tick();
    checks++;
    if (inflight !== 2'd3) begin errors++; $display("FAIL bp_refill got=%0d want=3", inflight); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    ap_start = 1; s0_ap_ready = 1; sf_full_n = 0; #1;
    checks++;
    if (ap_ready !== 1'b1 || sf_write !== 1'b1) begin
      errors++; $display("FAIL ff_first ready=%b write=%b want=1/1", ap_ready, sf_write);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sf_write !== 1'b1 || s0_ap_start !== 1'b0 || ap_idle !== 1'b0) begin
        errors++; $display("FAIL ff_pending cyc=%0d write=%b s0=%b idle=%b want=1/0/0", i, sf_write, s0_ap_start, ap_idle);
      end
      tick();
    end
    sf_full_n = 1; #1;
    checks++;
    if (sf_write !== 1'b1 || s0_ap_start !== 1'b0) begin
      errors++; $display("FAIL ff_drain write=%b s0=%b want=1/0", sf_write, s0_ap_start);
    end
    tick();
    checks++;
    if (s0_ap_start !== 1'b1 || inflight !== 2'd1) begin
      errors++; $display("FAIL ff_reopen s0=%b infl=%0d want=1/1", s0_ap_start, inflight);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    ap_start = 1; s0_ap_ready = 1; tick(); tick();
    last_ap_done = 1; #1;
    checks++;
    if (inflight !== 2'd2 || ap_ready !== 1'b1) begin
      errors++; $display("FAIL sim_setup infl=%0d rdy=%b want=2/1", inflight, ap_ready);
    end
    tick(); ap_start = 0; s0_ap_ready = 0;
    checks++;
    if (inflight !== 2'd2 || ap_done !== 1'b1) begin
      errors++; $display("FAIL sim_acc_cap infl=%0d done=%b want=2/1", inflight, ap_done);
    end
    ap_continue = 1; #1;
    checks++;
    if (last_ap_continue !== 1'b0) begin errors++; $display("FAIL sim_no_capture got=%b want=0", last_ap_continue); end
    tick(); ap_continue = 0;
    checks++;
    if (ap_done !== 1'b0 || last_ap_continue !== 1'b1) begin
      errors++; $display("FAIL sim_cleared done=%b lcont=%b want=0/1", ap_done, last_ap_continue);
    end
    tick(); last_ap_done = 0;
    checks++;
    if (ap_done !== 1'b1 || inflight !== 2'd1 || frames_done !== 16'd2) begin
      errors++; $display("FAIL sim_recapture done=%b infl=%0d fdone=%0d want=1/1/2", ap_done, inflight, frames_done);
    end
  endtask

  task automatic test_underflow_async_reset();
    do_reset();
    last_ap_done = 1; tick(); last_ap_done = 0;
    checks++;
    if (err_underflow !== 1'b1 || ap_done !== 1'b1 || inflight !== 2'd0) begin
      errors++; $display("FAIL uf_flag err=%b done=%b infl=%0d want=1/1/0", err_underflow, ap_done, inflight);
    end
    ap_continue = 1; tick(); ap_continue = 0;
    ap_start = 1; s0_ap_ready = 1; tick(); tick(); ap_start = 0; s0_ap_ready = 0;
    checks++;
    if (err_underflow !== 1'b1 || inflight !== 2'd2) begin
      errors++; $display("FAIL uf_sticky err=%b infl=%0d want=1/2", err_underflow, inflight);
    end
    #2 ap_rst_n = 0; #1;
    checks++;
    if (inflight !== 2'd0 || err_underflow !== 1'b0 || frames_started !== 16'd0 || ap_idle !== 1'b1 || ap_done !== 1'b0) begin
      errors++; $display("FAIL async_reset infl=%0d err=%b fst=%0d idle=%b done=%b want=0/0/0/1/0",
        inflight, err_underflow, frames_started, ap_idle, ap_done);
    end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      ap_start     = ($urandom_range(0, 3) != 0);
      s0_ap_ready  = ($urandom_range(0, 3) != 0);
      sf_full_n    = ($urandom_range(0, 4) != 0);
      last_ap_done = ($urandom_range(0, 2) == 0);
      ap_continue  = ($urandom_range(0, 1) == 0);
      #1;
      checks++;
      if (s0_ap_start !== m_gate() || ap_ready !== m_acc() || sf_write !== (m_acc() || m_pending)
          || ap_done !== m_hold || last_ap_continue !== !m_hold
          || ap_idle !== (m_inflight == 0 && !m_hold && !m_pending)) begin
        errors++; $display("FAIL rand_comb cyc=%0d s0=%b rdy=%b wr=%b done=%b lc=%b idle=%b model infl=%0d pend=%b hold=%b",
          i, s0_ap_start, ap_ready, sf_write, ap_done, last_ap_continue, ap_idle, m_inflight, m_pending, m_hold);
      end
      checks++;
      if (inflight !== 2'(m_inflight) || frames_started !== 16'(m_started)
          || frames_done !== 16'(m_done) || err_underflow !== m_err) begin
        errors++; $display("FAIL rand_state cyc=%0d infl=%0d/%0d fst=%0d/%0d fdn=%0d/%0d err=%b/%b (got/want)",
          i, inflight, m_inflight, frames_started, m_started, frames_done, m_done, err_underflow, m_err);
      end
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    ap_rst_n = 0;
    test_reset();
    test_single_frame();
    test_back_pressure();
    test_fifo_full();
    test_simultaneous();
    test_underflow_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
